// File: rtl/ps2_mouse_if.sv
// Byte stream from the PS/2 receiver in, cursor position, buttons and
// packet/sync status pulses out.
interface ps2_mouse_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
);
  logic [7:0]     received_data;
  logic           received_data_en;
  logic [X_W-1:0] x_position;
  logic [Y_W-1:0] y_position;
  logic           left_button;
  logic           right_button;
  logic           middle_button;
  logic           packet_valid;
  logic           sync_error;

  modport master (
    output received_data, received_data_en,
    input  x_position, y_position, left_button, right_button, middle_button,
    input  packet_valid, sync_error
  );

  modport slave (
    input  received_data, received_data_en,
    output x_position, y_position, left_button, right_button, middle_button,
    output packet_valid, sync_error
  );
endinterface

// File: rtl/ps2_mouse_tracker.sv
// Assembles 3-byte PS/2 mouse packets and tracks a clamped cursor position
// plus button state, with sync checking and inter-byte timeout resync.
module ps2_mouse_tracker #(
  parameter int SCREEN_W       = 320,
  parameter int SCREEN_H       = 240,
  parameter int X_W            = 10,
  parameter int Y_W            = 9,
  parameter int INIT_X         = 160,
  parameter int INIT_Y         = 120,
  parameter int X_SHIFT        = 1,
  parameter int Y_SHIFT        = 1,
  parameter int Y_INVERT       = 1,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic        clk,
  input logic        reset,
  ps2_mouse_if.slave bus
);

  typedef enum logic [1:0] {WAIT_B1, WAIT_B2, WAIT_B3, UPDATE} state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW    = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam logic [CNT_W-1:0]     TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic signed [CW-1:0] X_MAX   = CW'(SCREEN_W - 1);
  localparam logic signed [CW-1:0] Y_MAX   = CW'(SCREEN_H - 1);

  state_t           state;
  logic             en_q;
  logic             strobe;
  logic [7:0]       b1, b2, b3;
  logic [CNT_W-1:0] to_cnt;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;
  logic [2:0]       btn_q;
  logic             pv_q;
  logic             se_q;

  logic signed [8:0]    dx_p0, dy_p0, sdx_p0, sdy_p0;
  logic signed [CW-1:0] x_ext_p0, y_ext_p0, nx_p0, ny_p0;

  // Overflow flag forces the movement to the extreme of its sign.
  function automatic logic signed [8:0] sat_delta(input logic sgn, input logic ovf,
                                                  input logic [7:0] mag);
    if (ovf) return sgn ? 9'sh100 : 9'sh0FF;
    return {sgn, mag};
  endfunction

  function automatic logic [X_W-1:0] clamp_x(input logic signed [CW-1:0] v);
    if (v[CW-1])   return '0;
    if (v > X_MAX) return X_W'(SCREEN_W - 1);
    return v[X_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] clamp_y(input logic signed [CW-1:0] v);
    if (v[CW-1])   return '0;
    if (v > Y_MAX) return Y_W'(SCREEN_H - 1);
    return v[Y_W-1:0];
  endfunction

  assign strobe = bus.received_data_en & ~en_q;

  // Stage p0: decode captured packet into candidate positions
  always_comb begin
    dx_p0    = sat_delta(b1[4], b1[6], b2);
    dy_p0    = sat_delta(b1[5], b1[7], b3);
    sdx_p0   = dx_p0 >>> X_SHIFT;
    sdy_p0   = dy_p0 >>> Y_SHIFT;
    x_ext_p0 = $signed({{(CW-X_W){1'b0}}, x_q});
    y_ext_p0 = $signed({{(CW-Y_W){1'b0}}, y_q});
    nx_p0    = x_ext_p0 + {{(CW-9){sdx_p0[8]}}, sdx_p0};
    ny_p0    = (Y_INVERT != 0) ? y_ext_p0 - {{(CW-9){sdy_p0[8]}}, sdy_p0}
                               : y_ext_p0 + {{(CW-9){sdy_p0[8]}}, sdy_p0};
  end

  // Registered outputs and packet FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= WAIT_B1;
      en_q   <= 1'b0;
      to_cnt <= '0;
      x_q    <= X_W'(INIT_X);
      y_q    <= Y_W'(INIT_Y);
      btn_q  <= 3'b000;
      pv_q   <= 1'b0;
      se_q   <= 1'b0;
    end else begin
      en_q <= bus.received_data_en;
      pv_q <= 1'b0;
      se_q <= 1'b0;
      case (state)
        WAIT_B1, UPDATE: begin
          if (state == UPDATE) begin
            x_q   <= clamp_x(nx_p0);
            y_q   <= clamp_y(ny_p0);
            btn_q <= b1[2:0];
            pv_q  <= 1'b1;
          end
          to_cnt <= '0;
          state  <= WAIT_B1;
          // A strobe landing in UPDATE is treated as a fresh first byte.
          if (strobe) begin
            if (bus.received_data[3]) begin
              b1    <= bus.received_data;
              state <= WAIT_B2;
            end else begin
              se_q <= 1'b1;
            end
          end
        end
        WAIT_B2, WAIT_B3: begin
          if (strobe) begin
            to_cnt <= '0;
            if (state == WAIT_B2) begin
              b2    <= bus.received_data;
              state <= WAIT_B3;
            end else begin
              b3    <= bus.received_data;
              state <= UPDATE;
            end
          end else if (to_cnt == TO_LAST) begin
            state  <= WAIT_B1;
            se_q   <= 1'b1;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end
        default: state <= WAIT_B1;
      endcase
    end
  end

  assign bus.x_position    = x_q;
  assign bus.y_position    = y_q;
  assign bus.left_button   = btn_q[0];
  assign bus.right_button  = btn_q[1];
  assign bus.middle_button = btn_q[2];
  assign bus.packet_valid  = pv_q;
  assign bus.sync_error    = se_q;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed plus randomized bench for ps2_mouse_tracker against an
// integer-arithmetic model of cursor movement.
module tb_ps2_mouse_tracker;
  localparam int TO = 300;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   pv_cnt = 0;
  int   se_cnt = 0;
  int   exp_pv = 0;
  int   exp_se = 0;
  int   exp_x, exp_y, exp_btn;

  always #5 clk = ~clk;

  ps2_mouse_if #(.X_W(10), .Y_W(9)) bus ();

  ps2_mouse_tracker #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.packet_valid === 1'b1) pv_cnt++;
    if (bus.sync_error === 1'b1) se_cnt++;
    if (bus.packet_valid === 1'b1 || bus.sync_error === 1'b1) begin
      checks++;
      assert (!(bus.packet_valid === 1'b1 && bus.sync_error === 1'b1)) else begin
        errors++;
        $error("FAIL pv_se_overlap observed 1 expected 0");
      end
    end
  end

  function automatic int delta(input logic sgn, input logic ovf, input logic [7:0] m);
    if (ovf) return sgn ? -256 : 255;
    return sgn ? int'(m) - 256 : int'(m);
  endfunction

  function automatic int floor_div(input int d, input int s);
    int p;
    p = 1 << s;
    if (d >= 0) return d / p;
    return -((-d + p - 1) / p);
  endfunction

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic mdl_reset();
    exp_x = 160; exp_y = 120; exp_btn = 0;
  endtask

  task automatic mdl_apply(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    exp_x   = clamp(exp_x + floor_div(delta(b1[4], b1[6], b2), 1), 319);
    exp_y   = clamp(exp_y - floor_div(delta(b1[5], b1[7], b3), 1), 239);
    exp_btn = int'(b1[2:0]);
    exp_pv++;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_x"}, 32'(bus.x_position), exp_x);
    chk({tag, "_y"}, 32'(bus.y_position), exp_y);
    chk({tag, "_btn"}, {29'd0, bus.middle_button, bus.right_button, bus.left_button}, exp_btn);
  endtask

  task automatic chk_counts(input string tag);
    #1;
    chk({tag, "_pv_cnt"}, pv_cnt, exp_pv);
    chk({tag, "_se_cnt"}, se_cnt, exp_se);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    bus.received_data    = b;
    bus.received_data_en = 1'b1;
    repeat (hold) @(negedge clk);
    bus.received_data_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_pkt(input string tag, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input int hold);
    int last;
    send_byte(b1, hold);
    send_byte(b2, hold);
    mdl_apply(b1, b2, b3);
    last = (hold > 3) ? hold : 3;
    @(negedge clk);
    bus.received_data    = b3;
    bus.received_data_en = 1'b1;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == 1) chk({tag, "_pv_early"}, 32'(bus.packet_valid), 0);
      if (k == 2) begin
        chk({tag, "_pv"}, 32'(bus.packet_valid), 1);
        chk_outputs(tag);
      end
      if (k == 3) chk({tag, "_pv_late"}, 32'(bus.packet_valid), 0);
      if (k == hold) bus.received_data_en = 1'b0;
    end
    chk_counts(tag);
  endtask

  task automatic send_junk(input string tag, input logic [7:0] b);
    send_byte(b, 1);
    exp_se++;
    chk_counts(tag);
    chk_outputs(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mdl_reset();
  endtask

  initial begin
    int n;
    logic [7:0] r1, r2, r3;
    reset = 1'b1;
    bus.received_data    = 8'h00;
    bus.received_data_en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mdl_reset();
    chk_outputs("reset");
    repeat (100) @(negedge clk);
    chk_outputs("idle");
    chk_counts("idle");

    send_pkt("basic", 8'h09, 8'h10, 8'h08, 1);

    do_reset();
    send_pkt("neg16", 8'h18, 8'hF0, 8'h00, 1);
    send_pkt("neg1", 8'h18, 8'hFF, 8'h00, 1);

    do_reset();
    send_pkt("xovf1", 8'h48, 8'h00, 8'h00, 1);
    send_pkt("xovf2", 8'h48, 8'h00, 8'h00, 1);
    send_pkt("xovf3", 8'h48, 8'h00, 8'h00, 1);
    send_pkt("yovf1", 8'hB8, 8'h00, 8'h00, 1);
    send_pkt("yovf2", 8'hB8, 8'h00, 8'h00, 1);

    do_reset();
    send_junk("junk", 8'h00);
    send_byte(8'h08, 1);
    @(negedge clk);
    bus.received_data    = 8'h02;
    bus.received_data_en = 1'b1;
    n = 0;
    while (n < TO + 20) begin
      @(negedge clk);
      n++;
      if (n == 1) bus.received_data_en = 1'b0;
      if (bus.sync_error === 1'b1) break;
    end
    exp_se++;
    chk("timeout_seen", 32'((n >= TO) && (n <= TO + 2)), 1);
    chk_outputs("timeout");
    chk_counts("timeout");
    send_pkt("after_to", 8'h08, 8'h02, 8'h00, 1);

    send_pkt("hold3", 8'h0A, 8'h06, 8'hFA, 3);
    send_byte(8'h0C, 1);
    send_byte(8'h30, 1);
    do_reset();
    chk_outputs("midreset");
    chk_counts("midreset");
    send_pkt("post_rst", 8'h0C, 8'h30, 8'h20, 2);

    for (int i = 0; i < 40; i++) begin
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      r3 = 8'($urandom);
      if ($urandom_range(0, 4) == 0) send_junk("rnd_junk", r1 & 8'hF7);
      else send_pkt("rnd", r1 | 8'h08, r2, r3, int'($urandom_range(1, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_mouse_tracker.md
Name: ps2_mouse_tracker

Overview:
Consumes the byte stream from the PS/2 receiver (received_data / received_data_en) and assembles standard 3-byte PS/2 mouse packets. Tracks an on-screen cursor position and button state from those packets. Adds packet sync checking, inter-byte timeout resync, overflow saturation, power-of-two sensitivity scaling and parametrised screen clamping. Sits between the PS/2 receiver and the VGA/game logic.

Parameters:
SCREEN_W, 320, horizontal extent; x clamped to [0, SCREEN_W-1]
SCREEN_H, 240, vertical extent; y clamped to [0, SCREEN_H-1]
X_W, 10, width of x_position
Y_W, 9, width of y_position
INIT_X, 160, x_position reset value
INIT_Y, 120, y_position reset value
X_SHIFT, 1, dx arithmetic right-shift (sensitivity divisor 2^X_SHIFT)
Y_SHIFT, 1, dy arithmetic right-shift
Y_INVERT, 1, 1: PS/2 +dy moves cursor up (y decreases); 0: y increases
TIMEOUT_CYCLES, 50000, max clk cycles between bytes of one packet

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
received_data  in  8  byte from PS/2 receiver
received_data_en  in  1  byte valid; may stay high several cycles per byte
x_position  out  X_W  cursor x
y_position  out  Y_W  cursor y
left_button  out  1  packet byte1[0]
right_button  out  1  packet byte1[1]
middle_button  out  1  packet byte1[2]
packet_valid  out  1  1-cycle pulse on each applied packet
sync_error  out  1  1-cycle pulse on discarded byte or timeout

Behaviour:
- One clock, clk. Reset is synchronous and active-high; reset wins over all other events, including mid-packet.
- Reset values: x_position=INIT_X, y_position=INIT_Y, buttons=0, packet_valid=0, sync_error=0, state=WAIT_B1, timeout counter=0, en_q=0.
- Byte strobe: en_q is received_data_en registered. strobe = received_data_en & ~en_q. One strobe per byte regardless of how long en stays high.
- FSM states: WAIT_B1, WAIT_B2, WAIT_B3, UPDATE.
  - WAIT_B1, strobe with data[3]=1: capture b1, go to WAIT_B2.
  - WAIT_B1, strobe with data[3]=0: discard the byte, pulse sync_error next cycle, stay in WAIT_B1.
  - WAIT_B2, strobe: capture b2, go to WAIT_B3.
  - WAIT_B3, strobe: capture b3, go to UPDATE.
  - UPDATE: apply the packet and return to WAIT_B1. A strobe in this same cycle is processed as a WAIT_B1 byte (sync check applies).
- Timeout: counter clears on every strobe and on entry to WAIT_B1, counts in WAIT_B2/WAIT_B3, and saturates. On reaching TIMEOUT_CYCLES: go to WAIT_B1, pulse sync_error, discard the partial packet, leave outputs unchanged.
- Latency: strobe of b3 seen in cycle T; UPDATE is cycle T+1. New positions, buttons and packet_valid=1 are all visible in cycle T+2. packet_valid is high exactly one cycle.
- Arithmetic:
  - dx = 9-bit signed {b1[4], b2}. If b1[6] (X overflow) is set, dx = +255 when b1[4]=0, else -256.
  - dy = {b1[5], b3}, saturated the same way on b1[7].
  - sdx = dx >>> X_SHIFT and sdy = dy >>> Y_SHIFT. Shifts are arithmetic, rounding toward -inf (-1 >>> 1 = -1).
  - new_x = x + sdx. new_y = y - sdy if Y_INVERT, else y + sdy. Both are computed signed at max(X_W,Y_W)+2 bits, so there is no wrap.
  - Clamp: below 0 gives 0; above the max gives SCREEN_W-1 / SCREEN_H-1.
- Buttons update only in UPDATE, from b1[2:0].
- sync_error and packet_valid never assert in the same cycle from the same byte.

Test Plan:
- Reset, then idle 100 cycles -> x=160, y=120, buttons 0, no pulses.
- Bytes 0x09, 0x10, 0x08 (en high 1 cycle each) -> 2 cycles after b3 strobe: x=168, y=116, left=1, packet_valid single pulse.
- From reset: 0x18, 0xF0, 0x00 -> x=152. Then 0x18, 0xFF, 0x00 -> x=151 (confirms -1 >>> 1 = -1).
- Overflow/clamp: 0x48, 0x00, 0x00 -> dx saturates to +255, x=160+127=287. Repeat -> x=319 and holds. 0xB8, 0x00, 0x00 repeated -> y=239 and holds.
- Resync: byte 0x00 in WAIT_B1 -> sync_error pulse, no state change. Then 0x08, 0x02, then stall TIMEOUT_CYCLES -> sync_error pulse, no position change. Next packet 0x08, 0x02, 0x00 -> x=161.
- received_data_en held high 3 cycles per byte -> each byte counted once, packet applied once. Reset asserted after b2 -> outputs return to init; following full packet decodes normally.
